abr_prim_slice_sequencer: RTL

Sequences one wide input word out as a stream of narrow slices, `OutW` bits per beat, lowest slice first, with valid/ready handshakes on both sides. It registers the accepted word and walks an internal `abr_prim_slicer` select index across it. It emits only the number of slices the producer requests and flags the final beat. It sits between wide producers (hash/sampler state words) and narrow consumers (byte/limb-wide FIFOs, bus packers) in the datapath.

---
 rtl/abr_prim_slice_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/abr_prim_slice_sequencer.sv
// Wide-to-narrow slice sequencer: registers one wide word and streams it out
// OutW bits per beat, lowest slice first, for a producer-selected slice count.

module abr_prim_slicer #(
  parameter int InW    = 64,
  parameter int OutW   = 8,
  parameter int IndexW = 4
) (
  input  logic [IndexW-1:0] sel_i,
  input  logic [InW-1:0]    data_i,
  output logic [OutW-1:0]   data_o
);

  localparam int PadW = OutW * (2 ** IndexW);

  // Zero-extend so the top fractional slice reads zeros above bit InW-1.
  logic [PadW-1:0] padded;

  assign padded = PadW'(data_i);
  assign data_o = padded[sel_i*OutW +: OutW];

endmodule

module abr_prim_slice_sequencer #(
  parameter int InW    = 64,
  parameter int OutW   = 8,
  parameter int IndexW = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [InW-1:0]    in_data_i,
  input  logic [IndexW:0]   in_nslices_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [OutW-1:0]   out_data_o,
  output logic [IndexW-1:0] out_idx_o,
  output logic              out_last_o,
  output logic              busy_o
);

  localparam int NumSlices = (InW + OutW - 1) / OutW;
  localparam logic [IndexW:0] NumSlicesN = (IndexW+1)'(NumSlices);

  if (InW > OutW * (2 ** IndexW)) begin : gen_param_check
    $error("abr_prim_slice_sequencer: IndexW too small to address all slices");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e              state_q;
  logic [InW-1:0]      data_q;
  logic [IndexW-1:0]   idx_q;
  logic [IndexW-1:0]   last_idx_q;

  logic [IndexW:0]     eff_n;
  logic [IndexW-1:0]   last_idx_d;
  logic                at_last;
  logic                in_fire;
  logic                out_fire;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    eff_n = in_nslices_i;
    if ((in_nslices_i == '0) || (in_nslices_i > NumSlicesN)) begin
      eff_n = NumSlicesN;
    end
    last_idx_d = IndexW'(eff_n - (IndexW+1)'(1));
  end

  assign at_last     = (idx_q == last_idx_q);
  assign out_valid_o = (state_q == SEND);
  assign out_fire    = out_valid_o & out_ready_i;
  assign out_last_o  = out_valid_o & at_last;
  assign out_idx_o   = idx_q;
  assign busy_o      = (state_q == SEND);
  assign in_ready_o  = ~flush_i & ((state_q == IDLE) | (out_fire & out_last_o));
  assign in_fire     = in_valid_i & in_ready_o;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      data_q     <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
    end else if (flush_i) begin
      // A slice handshaked this cycle is consumed; the rest of the word is dropped.
      state_q <= IDLE;
      idx_q   <= '0;
    end else if (in_fire) begin
      state_q    <= SEND;
      data_q     <= in_data_i;
      idx_q      <= '0;
      last_idx_q <= last_idx_d;
    end else if (out_fire) begin
      if (!at_last) begin
        idx_q <= idx_q + IndexW'(1);
      end else begin
        state_q <= IDLE;
      end
    end
  end

  abr_prim_slicer #(
    .InW    (InW),
    .OutW   (OutW),
    .IndexW (IndexW)
  ) u_slicer (
    .sel_i  (idx_q),
    .data_i (data_q),
    .data_o (out_data_o)
  );

endmodule
